// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-to-decode stream: valid/ready handshake carrying {pc, instr}.
interface instr_fetch_ctrl_if;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    modport master (output if_valid, output if_instr, output if_pc, input if_ready);
    modport slave  (input if_valid, input if_instr, input if_pc, output if_ready);
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction-fetch controller: drives a 1-cycle-latency ROM, buffers returned words in a
// 2-entry queue toward decode, handles redirects and halts after a SYSTEM instruction.
//
// state | meaning
// RUN   | issuing reads and pushing returned words
// HALT  | SYSTEM word queued; no issue, in-flight data dropped, queue drains
module instr_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned ADDR_W   = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_en,
    output logic [ADDR_W-1:0]     rom_addr,
    input  logic [31:0]           rom_instr,
    instr_fetch_ctrl_if.master    dec,
    input  logic                  redirect,
    input  logic [31:0]           redirect_pc,
    output logic                  redirect_misalign,
    output logic                  halted
);
    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] inflight_pc_q;
    logic        inflight_q;
    logic [1:0]  count;
    logic [31:0] q_pc    [2];
    logic [31:0] q_instr [2];

    logic        pop;
    logic        push;
    logic        issue;
    logic [1:0]  occ;

    assign occ   = count + {1'b0, inflight_q};
    assign pop   = dec.if_valid & dec.if_ready;
    assign push  = inflight_q & (state == RUN) & ~redirect;
    // A pop frees a slot at this edge, so a read can still be issued when full.
    assign issue = (state == RUN) & fetch_en & ~redirect & ((occ < 2'd2) | pop);

    assign rom_addr     = fetch_pc[ADDR_W+1:2];
    assign dec.if_valid = (count != 2'd0);
    assign dec.if_instr = dec.if_valid ? q_instr[0] : 32'h0000_0013;
    assign dec.if_pc    = dec.if_valid ? q_pc[0]    : 32'h0000_0000;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= RUN;
            halted            <= 1'b0;
            fetch_pc          <= RESET_PC;
            inflight_q        <= 1'b0;
            inflight_pc_q     <= 32'h0;
            count             <= 2'd0;
            redirect_misalign <= 1'b0;
        end else if (redirect) begin
            state             <= RUN;
            halted            <= 1'b0;
            fetch_pc          <= {redirect_pc[31:2], 2'b00};
            inflight_q        <= 1'b0;
            count             <= 2'd0;
            redirect_misalign <= |redirect_pc[1:0];
        end else begin
            redirect_misalign <= 1'b0;
            inflight_q        <= issue;
            if (issue) begin
                inflight_pc_q <= fetch_pc;
                fetch_pc      <= fetch_pc + 32'd4;
            end
            if (push && rom_instr[6:0] == 7'h73) begin
                state  <= HALT;
                halted <= 1'b1;
            end
            // Head is always entry 0; entries shift forward on pop.
            if (push && pop) begin
                if (count == 2'd2) begin
                    q_pc[0]    <= q_pc[1];
                    q_instr[0] <= q_instr[1];
                    q_pc[1]    <= inflight_pc_q;
                    q_instr[1] <= rom_instr;
                end else begin
                    q_pc[0]    <= inflight_pc_q;
                    q_instr[0] <= rom_instr;
                end
            end else if (pop) begin
                q_pc[0]    <= q_pc[1];
                q_instr[0] <= q_instr[1];
                count      <= count - 2'd1;
            end else if (push) begin
                if (count == 2'd0) begin
                    q_pc[0]    <= inflight_pc_q;
                    q_instr[0] <= rom_instr;
                end else begin
                    q_pc[1]    <= inflight_pc_q;
                    q_instr[1] <= rom_instr;
                end
                count <= count + 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: queue-based reference model plus an in-order stream check,
// and a second instance with RESET_PC near the ROM wrap point.
module tb_instr_fetch_ctrl;
    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic [9:0]  rom_addr;
    logic [31:0] rom_instr;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        redirect_misalign;
    logic        halted;

    logic [9:0]  rom_addr2;
    logic [31:0] rom_instr2;
    logic        redirect_misalign2;
    logic        halted2;

    instr_fetch_ctrl_if dec_if ();
    instr_fetch_ctrl_if dec_if2 ();

    instr_fetch_ctrl #(.RESET_PC(32'h0), .ADDR_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .rom_addr(rom_addr),
        .rom_instr(rom_instr), .dec(dec_if), .redirect(redirect),
        .redirect_pc(redirect_pc), .redirect_misalign(redirect_misalign), .halted(halted)
    );

    instr_fetch_ctrl #(.RESET_PC(32'h0000_0FF8), .ADDR_W(10)) dut2 (
        .clk(clk), .rst_n(rst_n), .fetch_en(1'b1), .rom_addr(rom_addr2),
        .rom_instr(rom_instr2), .dec(dec_if2), .redirect(1'b0),
        .redirect_pc(32'h0), .redirect_misalign(redirect_misalign2), .halted(halted2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int halt_idx = -1;

    function automatic logic [31:0] rom_word(input logic [9:0] idx);
        if (halt_idx >= 0 && int'(idx) == halt_idx) return 32'h0000_0073;
        return {2'b00, idx, 20'h00013};
    endfunction

    always @(posedge clk) rom_instr  <= rom_word(rom_addr);
    always @(posedge clk) rom_instr2 <= {2'b00, rom_addr2, 20'h00013};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
        end
    endtask

    // Reference model state
    logic [31:0] mq_pc[$];
    logic [31:0] mq_in[$];
    bit          m_ok = 0;
    bit          m_inf;
    logic [31:0] m_inf_pc;
    logic [31:0] m_pc;
    bit          m_run;
    bit          m_mis;
    logic [31:0] exp_next;
    int          k2 = 100;

    task automatic cycle();
        bit          pop;
        bit          iss;
        logic [31:0] d;
        logic [9:0]  a2;
        #1;
        pop = (mq_pc.size() != 0) && dec_if.if_ready;
        if (m_ok) begin
            chk("valid",    {31'b0, dec_if.if_valid}, {31'b0, mq_pc.size() != 0});
            chk("pc",       dec_if.if_pc,    (mq_pc.size() != 0) ? mq_pc[0] : 32'h0);
            chk("instr",    dec_if.if_instr, (mq_pc.size() != 0) ? mq_in[0] : 32'h13);
            chk("halted",   {31'b0, halted}, {31'b0, !m_run});
            chk("misalign", {31'b0, redirect_misalign}, {31'b0, m_mis});
            chk("rom_addr", {22'b0, rom_addr}, {22'b0, m_pc[11:2]});
            chk("no_ovf",   {31'b0, ({1'b0, dut.count} + {2'b0, dut.inflight_q}) <= 3'd2}, 32'd1);
            if (pop && rst_n) begin
                chk("order",    dec_if.if_pc, exp_next);
                chk("rom_data", dec_if.if_instr, rom_word(exp_next[11:2]));
                exp_next = exp_next + 32'd4;
            end
        end
        if (k2 < 8) begin
            a2 = 10'd1022 + 10'(k2);
            chk("w_addr",  {22'b0, rom_addr2}, {22'b0, a2});
            chk("w_valid", {31'b0, dec_if2.if_valid}, {31'b0, k2 >= 2});
            if (k2 >= 2) begin
                chk("w_pc",    dec_if2.if_pc, 32'h0000_0FF8 + 32'(4 * (k2 - 2)));
                chk("w_instr", dec_if2.if_instr,
                    {2'b00, 10'(32'h3FE + 32'(k2 - 2)), 20'h00013});
            end
        end

        iss = m_run && fetch_en && !redirect && (((mq_pc.size() + int'(m_inf)) < 2) || pop);
        if (!rst_n) begin
            mq_pc.delete(); mq_in.delete();
            m_inf = 0; m_pc = 32'h0; m_run = 1; m_mis = 0; exp_next = 32'h0; m_ok = 1;
            k2 = 0;
        end else begin
            if (k2 < 100) k2++;
            if (redirect) begin
                mq_pc.delete(); mq_in.delete();
                m_inf = 0; m_run = 1;
                m_pc = {redirect_pc[31:2], 2'b00};
                m_mis = |redirect_pc[1:0];
                exp_next = m_pc;
            end else begin
                m_mis = 0;
                if (pop) begin
                    void'(mq_pc.pop_front());
                    void'(mq_in.pop_front());
                end
                if (m_inf && m_run) begin
                    d = rom_word(m_inf_pc[11:2]);
                    mq_pc.push_back(m_inf_pc);
                    mq_in.push_back(d);
                    if (d[6:0] == 7'h73) m_run = 0;
                end
                if (iss) begin
                    m_inf_pc = m_pc;
                    m_pc = m_pc + 32'd4;
                end
                m_inf = iss;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; fetch_en = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
        dec_if.if_ready  = 1'b1;
        dec_if2.if_ready = 1'b1;
        @(negedge clk);

        // Reset and free-running stream
        repeat (2) cycle();
        rst_n = 1'b1;
        repeat (12) cycle();

        // Backpressure while pc 0x10 is at the head
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (mq_pc.size() != 0 && mq_pc[0] == 32'h10) break;
            cycle();
        end
        dec_if.if_ready = 1'b0;
        repeat (5) cycle();
        dec_if.if_ready = 1'b1;
        repeat (6) cycle();

        // Redirect with a full queue, aligned then misaligned target
        dec_if.if_ready = 1'b0;
        repeat (4) cycle();
        redirect = 1'b1; redirect_pc = 32'h200; cycle();
        redirect = 1'b0; dec_if.if_ready = 1'b1;
        repeat (6) cycle();
        dec_if.if_ready = 1'b0;
        repeat (3) cycle();
        redirect = 1'b1; redirect_pc = 32'h203; cycle();
        redirect = 1'b0; dec_if.if_ready = 1'b1;
        repeat (6) cycle();

        // SYSTEM word at pc 0x14, then redirect out of HALT
        halt_idx = 5;
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        repeat (15) cycle();
        redirect = 1'b1; redirect_pc = 32'h40; cycle();
        redirect = 1'b0;
        repeat (10) cycle();

        // Reset pulse during backpressure
        dec_if.if_ready = 1'b0;
        repeat (3) cycle();
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        dec_if.if_ready = 1'b1;
        repeat (8) cycle();

        // Randomized traffic
        halt_idx = 32;
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            fetch_en        = ($urandom % 8) != 0;
            dec_if.if_ready = ($urandom % 4) != 0;
            redirect        = ($urandom % 25) == 0;
            redirect_pc     = $urandom & 32'h0000_03FF;
            rst_n           = ($urandom % 400) != 0;
            cycle();
        end
        rst_n = 1'b1; redirect = 1'b0;
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
